// File: rtl/key_event_mapper_pkg.sv
// Shared definitions for the keyboard event mapper.
// - Key indices for the held-key vector, as seen by the player.
// - Source indices: 10 primary keys plus 4 arrow aliases.
// - Set-2 scan codes. Bit 8 marks the E0-extended prefix.
// - Direction enum and helpers for merging sources into keys.
package key_event_mapper_pkg;

    localparam int unsigned NUM_KEYS = 10;
    localparam int unsigned NUM_SRC  = 14;

    // Key indices in key_down / key_press
    localparam int unsigned KEY_DIGIT1 = 0;
    localparam int unsigned KEY_DIGIT2 = 1;
    localparam int unsigned KEY_DIGIT3 = 2;
    localparam int unsigned KEY_DIGIT4 = 3;
    localparam int unsigned KEY_UP     = 4;
    localparam int unsigned KEY_LEFT   = 5;
    localparam int unsigned KEY_DOWN   = 6;
    localparam int unsigned KEY_RIGHT  = 7;
    localparam int unsigned KEY_SPACE  = 8;
    localparam int unsigned KEY_ENTER  = 9;

    // Source indices.
    // A primary source shares its index with the key it drives.
    localparam logic [3:0] SRC_DIGIT1      = 4'd0;
    localparam logic [3:0] SRC_DIGIT2      = 4'd1;
    localparam logic [3:0] SRC_DIGIT3      = 4'd2;
    localparam logic [3:0] SRC_DIGIT4      = 4'd3;
    localparam logic [3:0] SRC_W           = 4'd4;
    localparam logic [3:0] SRC_A           = 4'd5;
    localparam logic [3:0] SRC_S           = 4'd6;
    localparam logic [3:0] SRC_D           = 4'd7;
    localparam logic [3:0] SRC_SPACE       = 4'd8;
    localparam logic [3:0] SRC_ENTER       = 4'd9;
    localparam logic [3:0] SRC_ARROW_UP    = 4'd10;
    localparam logic [3:0] SRC_ARROW_LEFT  = 4'd11;
    localparam logic [3:0] SRC_ARROW_DOWN  = 4'd12;
    localparam logic [3:0] SRC_ARROW_RIGHT = 4'd13;

    // Scan codes: {E0 prefix, set-2 code}
    localparam logic [8:0] CODE_1       = 9'h016;
    localparam logic [8:0] CODE_2       = 9'h01E;
    localparam logic [8:0] CODE_3       = 9'h026;
    localparam logic [8:0] CODE_4       = 9'h025;
    localparam logic [8:0] CODE_W       = 9'h01D;
    localparam logic [8:0] CODE_A       = 9'h01C;
    localparam logic [8:0] CODE_S       = 9'h01B;
    localparam logic [8:0] CODE_D       = 9'h023;
    localparam logic [8:0] CODE_SPACE   = 9'h029;
    localparam logic [8:0] CODE_ENTER   = 9'h05A;
    localparam logic [8:0] CODE_E0_UP   = 9'h175;
    localparam logic [8:0] CODE_E0_LEFT = 9'h16B;
    localparam logic [8:0] CODE_E0_DOWN = 9'h172;
    localparam logic [8:0] CODE_E0_RGHT = 9'h174;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    function automatic logic is_left_src(input logic [3:0] idx);
        return (idx == SRC_A) || (idx == SRC_ARROW_LEFT);
    endfunction

    function automatic logic is_right_src(input logic [3:0] idx);
        return (idx == SRC_D) || (idx == SRC_ARROW_RIGHT);
    endfunction

    // OR every source onto the key it drives.
    function automatic logic [NUM_KEYS-1:0] raw_from_src(input logic [NUM_SRC-1:0] src);
        logic [NUM_KEYS-1:0] raw;
        raw            = src[NUM_KEYS-1:0];
        raw[KEY_UP]    = src[SRC_W] | src[SRC_ARROW_UP];
        raw[KEY_LEFT]  = src[SRC_A] | src[SRC_ARROW_LEFT];
        raw[KEY_DOWN]  = src[SRC_S] | src[SRC_ARROW_DOWN];
        raw[KEY_RIGHT] = src[SRC_D] | src[SRC_ARROW_RIGHT];
        return raw;
    endfunction

    // Resolve a left/right conflict.
    // When both are held, only the direction pressed last is reported.
    function automatic logic [NUM_KEYS-1:0] resolve_lr(input logic [NUM_KEYS-1:0] raw,
                                                       input dir_e last_dir);
        logic [NUM_KEYS-1:0] keys;
        keys = raw;
        if (raw[KEY_LEFT] && raw[KEY_RIGHT]) begin
            keys[KEY_LEFT]  = (last_dir == DIR_LEFT);
            keys[KEY_RIGHT] = (last_dir == DIR_RIGHT);
        end
        return keys;
    endfunction

endpackage

// File: rtl/key_event_mapper_lut.sv
// Combinational scan-code decoder.
//   evt_code : {E0 prefix, set-2 scan code}
//   hit      : 1 when the code belongs to a game key
//   src_idx  : source register index for the code (valid when hit=1)
// Non-extended codes must have bit 8 clear.
// For example, 0x75 without the prefix is keypad 8, which is not a game key.
module key_code_lut
    import key_event_mapper_pkg::*;
(
    input  logic [8:0] evt_code,
    output logic       hit,
    output logic [3:0] src_idx
);

    always_comb begin
        hit     = 1'b1;
        src_idx = '0;
        unique case (evt_code)
            CODE_1:       src_idx = SRC_DIGIT1;
            CODE_2:       src_idx = SRC_DIGIT2;
            CODE_3:       src_idx = SRC_DIGIT3;
            CODE_4:       src_idx = SRC_DIGIT4;
            CODE_W:       src_idx = SRC_W;
            CODE_A:       src_idx = SRC_A;
            CODE_S:       src_idx = SRC_S;
            CODE_D:       src_idx = SRC_D;
            CODE_SPACE:   src_idx = SRC_SPACE;
            CODE_ENTER:   src_idx = SRC_ENTER;
            CODE_E0_UP:   src_idx = SRC_ARROW_UP;
            CODE_E0_LEFT: src_idx = SRC_ARROW_LEFT;
            CODE_E0_DOWN: src_idx = SRC_ARROW_DOWN;
            CODE_E0_RGHT: src_idx = SRC_ARROW_RIGHT;
            default:      hit     = 1'b0;
        endcase
    end

endmodule

// File: rtl/key_event_mapper.sv
// Converts PS/2 make/break events into the held-key vector used by the player.
// - WASD and the arrow keys drive the same bits.
// - Left/right conflicts report only the direction pressed last.
// - An idle timeout releases all keys, which recovers from a lost break code.
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   evt_valid  one-cycle strobe: evt_code/evt_make valid
//   evt_code   {E0 prefix, set-2 scan code}
//   evt_make   1 = make/typematic repeat, 0 = break
//   key_down   registered held state (0-3 digits, 4 up, 5 left, 6 down, 7 right, 8 space, 9 enter)
//   key_press  one-cycle pulse on each 0->1 edge of key_down
//   timeout    one-cycle pulse when the idle release-all fires
module key_event_mapper
    import key_event_mapper_pkg::*;
#(
    parameter int unsigned TIMEOUT = 100_000_000,
    parameter int unsigned CNT_W   = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_valid,
    input  logic [8:0] evt_code,
    input  logic       evt_make,
    output logic [9:0] key_down,
    output logic [9:0] key_press,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic                lut_hit;
    logic [3:0]          lut_src;

    logic [NUM_SRC-1:0]  src_q, src_d;
    dir_e                dir_q, dir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic                timeout_q, timeout_d;
    logic [NUM_KEYS-1:0] raw_q;

    key_code_lut u_lut (
        .evt_code (evt_code),
        .hit      (lut_hit),
        .src_idx  (lut_src)
    );

    assign raw_q = raw_from_src(src_q);

    always_comb begin
        src_d     = src_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        // An event takes priority over the timeout.
        // If both land in the same cycle, the counter just clears.
        if (evt_valid) begin
            cnt_d = '0;
            if (lut_hit) begin
                src_d[lut_src] = evt_make;
                if (evt_make && is_left_src(lut_src)) begin
                    dir_d = DIR_LEFT;
                end else if (evt_make && is_right_src(lut_src)) begin
                    dir_d = DIR_RIGHT;
                end
            end
        end else if (raw_q == '0) begin
            cnt_d = '0;
        end else if (cnt_q >= TIMEOUT_C) begin
            src_d     = '0;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // key_down and key_press are registered from the next source state.
        // This gives key_down one edge after the event, with its press pulse
        // in the same cycle.
        key_down_d  = resolve_lr(raw_from_src(src_d), dir_d);
        key_press_d = key_down_d & ~key_down_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q       <= '0;
            dir_q       <= DIR_LEFT;
            cnt_q       <= '0;
            key_down_q  <= '0;
            key_press_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            src_q       <= src_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            key_down_q  <= key_down_d;
            key_press_q <= key_press_d;
            timeout_q   <= timeout_d;
        end
    end

    assign key_down  = key_down_q;
    assign key_press = key_press_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_key_event_mapper.sv
module tb_key_event_mapper;

    localparam int unsigned TO = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       evt_valid = 1'b0;
    logic [8:0] evt_code = '0;
    logic       evt_make = 1'b0;
    logic [9:0] key_down;
    logic [9:0] key_press;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state: the set of scan codes currently held, keyed by code.
    int         key_of[int];
    bit         held[int];
    bit         last_right;
    int         idle;
    logic [9:0] exp_down, exp_press;
    logic       exp_to;

    int pool [17] = '{'h016, 'h01E, 'h026, 'h025, 'h01D, 'h01C, 'h01B, 'h023, 'h029,
                      'h05A, 'h175, 'h16B, 'h172, 'h174, 'h044, 'h075, 'h15A};

    key_event_mapper #(.TIMEOUT(TO), .CNT_W(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_make  (evt_make),
        .key_down  (key_down),
        .key_press (key_press),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_keys();
        logic [9:0] r = '0;
        logic [9:0] k;
        foreach (held[c]) r[key_of[c]] = 1'b1;
        k = r;
        if (r[5] && r[7]) begin
            k[5] = !last_right;
            k[7] = last_right;
        end
        return k;
    endfunction

    task automatic model_reset();
        held.delete();
        last_right = 1'b0;
        idle       = 0;
        exp_down   = '0;
        exp_press  = '0;
        exp_to     = 1'b0;
    endtask

    task automatic model_step(input bit v, input int code, input bit mk);
        logic [9:0] nd;
        exp_to = 1'b0;
        if (v) begin
            idle = 0;
            if (key_of.exists(code)) begin
                if (mk) begin
                    held[code] = 1'b1;
                    if (key_of[code] == 5) last_right = 1'b0;
                    if (key_of[code] == 7) last_right = 1'b1;
                end else if (held.exists(code)) begin
                    held.delete(code);
                end
            end
        end else if (held.num() == 0) begin
            idle = 0;
        end else if (idle == int'(TO)) begin
            held.delete();
            exp_to = 1'b1;
            idle   = 0;
        end else begin
            idle++;
        end
        nd        = model_keys();
        exp_press = nd & ~exp_down;
        exp_down  = nd;
    endtask

    // One clock of stimulus.
    // The model is stepped on the edge, and the outputs are checked 1 ns later.
    task automatic cycle(input bit v, input int code, input bit mk);
        evt_valid = v;
        evt_code  = 9'(code);
        evt_make  = mk;
        @(posedge clk);
        model_step(v, code, mk);
        #1;
        evt_valid = 1'b0;
        chk("key_down", key_down, exp_down);
        chk("key_press", key_press, exp_press);
        chk("timeout", {9'b0, timeout}, {9'b0, exp_to});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_down", key_down, '0);
        chk("rst_press", key_press, '0);
        chk("rst_timeout", {9'b0, timeout}, '0);
        rst = 1'b0;
    endtask

    initial begin
        key_of['h016] = 0; key_of['h01E] = 1; key_of['h026] = 2; key_of['h025] = 3;
        key_of['h01D] = 4; key_of['h175] = 4;
        key_of['h01C] = 5; key_of['h16B] = 5;
        key_of['h01B] = 6; key_of['h172] = 6;
        key_of['h023] = 7; key_of['h174] = 7;
        key_of['h029] = 8; key_of['h05A] = 9;
        model_reset();

        @(posedge clk);
        do_reset();

        // 1: W press, then typematic repeats
        cycle(1, 'h01D, 1);
        chk("t1_down", key_down, 10'h010);
        chk("t1_press", key_press, 10'h010);
        repeat (3) begin
            cycle(1, 'h01D, 1);
            chk("t1_repeat_press", key_press, 10'h000);
        end
        cycle(0, 0, 0);

        // 2: left/right priority
        do_reset();
        cycle(1, 'h01C, 1);
        cycle(1, 'h023, 1);
        chk("t2_lr", {7'b0, key_down[7:5]}, 10'b100);
        cycle(1, 'h023, 0);
        chk("t2_left_back", {9'b0, key_down[5]}, 10'd1);
        chk("t2_left_pulse", {9'b0, key_press[5]}, 10'd1);
        cycle(1, 'h16B, 1);
        cycle(1, 'h174, 1);
        cycle(1, 'h16B, 1);
        chk("t2_repeat_left", {7'b0, key_down[7:5]}, 10'b001);

        // 3: alias merge
        do_reset();
        cycle(1, 'h01D, 1);
        cycle(1, 'h175, 1);
        cycle(1, 'h01D, 0);
        chk("t3_alias_hold", {9'b0, key_down[4]}, 10'd1);
        cycle(1, 'h175, 0);
        chk("t3_alias_rel", {9'b0, key_down[4]}, 10'd0);

        // 4: idle timeout
        do_reset();
        cycle(1, 'h029, 1);
        repeat (TO) cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("t4_timeout", {9'b0, timeout}, 10'd1);
        chk("t4_released", key_down, 10'h000);
        cycle(0, 0, 0);
        chk("t4_pulse_end", {9'b0, timeout}, 10'd0);

        // 5: an event arriving with the timeout wins
        do_reset();
        cycle(1, 'h029, 1);
        repeat (TO) cycle(0, 0, 0);
        cycle(1, 'h029, 1);
        chk("t5_no_timeout", {9'b0, timeout}, 10'd0);
        chk("t5_space_held", {9'b0, key_down[8]}, 10'd1);

        // 6: ignored codes, stray break, and async reset mid-hold
        do_reset();
        cycle(1, 'h029, 1);
        cycle(1, 'h044, 1);
        chk("t6_unknown", key_down, 10'h100);
        cycle(1, 'h05A, 0);
        chk("t6_stray_break", key_down, 10'h100);
        chk("t6_stray_press", key_press, 10'h000);
        rst = 1'b1;
        #1;
        chk("t6_async_down", key_down, '0);
        chk("t6_async_press", key_press, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (3) cycle(0, 0, 0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), pool[$urandom_range(0, 16)],
                  1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
